// File: rtl/sram_controller.sv
// sram_controller: turns each 32-bit MEM-stage load/store into two sequenced
// 16-bit accesses to an asynchronous SRAM (low halfword first), holding
// o_Ready low to freeze the pipeline until the transaction completes.
module sram_controller #(
  parameter int unsigned SRAM_WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_Read_Enable,
  input  logic        i_Write_Enable,
  input  logic [31:0] i_Address,
  input  logic [31:0] i_Write_Data,
  output logic [31:0] o_Read_Data,
  output logic        o_Ready,
  output logic [17:0] o_SRAM_Address,
  output logic [15:0] o_SRAM_Dq_Out,
  output logic        o_SRAM_Dq_Oe,
  input  logic [15:0] i_SRAM_Dq_In,
  output logic        o_SRAM_We_N,
  output logic        o_SRAM_Oe_N,
  output logic        o_SRAM_Ce_N
);

  localparam int unsigned CW = $clog2(SRAM_WAIT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SRAM_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  logic          request;
  logic          last;
  logic [31:0]   addr_off;

  logic          is_write;
  logic [16:0]   word;
  logic [31:0]   wdata;
  logic [15:0]   rdata_lo;

  assign request  = i_Read_Enable | i_Write_Enable;
  assign last     = (cnt == CNT_LAST);
  // Data region starts at byte 1024; lower addresses wrap modulo 2^32.
  assign addr_off = i_Address - 32'd1024;

  // State and wait-counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and wait-counter sequencing
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (request) begin
          state_next = LOW;
          cnt_next   = '0;
        end
      end
      LOW: begin
        if (last) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (last) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // SRAM strobes, bus drive and pipeline stall, decoded from state only so
  // that an asynchronous reset releases the SRAM without waiting for a clock
  always_comb begin
    o_Ready        = 1'b1;
    o_SRAM_Address = '0;
    o_SRAM_Dq_Out  = '0;
    o_SRAM_Dq_Oe   = 1'b0;
    o_SRAM_We_N    = 1'b1;
    o_SRAM_Oe_N    = 1'b1;
    o_SRAM_Ce_N    = 1'b1;
    case (state)
      IDLE: begin
        o_Ready = ~request;
      end
      LOW: begin
        o_Ready        = 1'b0;
        o_SRAM_Ce_N    = 1'b0;
        o_SRAM_Address = {word, 1'b0};
        o_SRAM_We_N    = ~is_write;
        o_SRAM_Oe_N    = is_write;
        o_SRAM_Dq_Oe   = is_write;
        o_SRAM_Dq_Out  = is_write ? wdata[15:0] : '0;
      end
      HIGH: begin
        o_Ready        = 1'b0;
        o_SRAM_Ce_N    = 1'b0;
        o_SRAM_Address = {word, 1'b1};
        o_SRAM_We_N    = ~is_write;
        o_SRAM_Oe_N    = is_write;
        o_SRAM_Dq_Oe   = is_write;
        o_SRAM_Dq_Out  = is_write ? wdata[31:16] : '0;
      end
      DONE: begin
        o_Ready = 1'b1;
      end
      default: begin
        o_Ready = 1'b1;
      end
    endcase
  end

  // Request latches: captured once in IDLE so mid-transaction input changes
  // cannot disturb the SRAM access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_write <= 1'b0;
      word     <= '0;
      wdata    <= '0;
    end else if (state == IDLE && request) begin
      is_write <= i_Write_Enable;
      word     <= 17'(addr_off >> 2);
      wdata    <= i_Write_Data;
    end
  end

  // Read assembly: the low half is held internally and the upper half is
  // merged straight into o_Read_Data on the edge into DONE, so an aborted
  // load never leaves a half-updated result visible
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_lo    <= '0;
      o_Read_Data <= '0;
    end else begin
      if (state == LOW && last && !is_write) begin
        rdata_lo <= i_SRAM_Dq_In;
      end
      if (state == HIGH && last && !is_write) begin
        o_Read_Data <= {i_SRAM_Dq_In, rdata_lo};
      end
    end
  end

endmodule
